// File: rtl/tmr_flip_scrubber.sv
// Purpose: triplicated register bank with flip injection, majority-voted reads and a background repair scrubber.
// Latency: reads return one cycle after rd_en; scrubbing costs 3 cycles per clean word and 4 per repaired word.
// Backpressure: none; user writes always win over the scrubber, which abandons or suppresses a repair on that word.
module tmr_flip_scrubber #(
    parameter  int N     = 16,
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [N-1:0]     wr_data,
    input  logic             flip_en,
    input  logic [1:0]       flip_copy,
    input  logic [AW-1:0]    flip_addr,
    input  logic [N-1:0]     flip_mask,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [N-1:0]     rd_data,
    output logic             rd_valid,
    input  logic             scrub_en,
    output logic             patch_pulse,
    output logic [AW-1:0]    patch_addr,
    output logic [CNT_W-1:0] patch_count,
    output logic             scrub_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_PATCH,
        S_ADVANCE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_ptr;
    logic [N-1:0]      r_bank     [3][DEPTH];
    logic [N-1:0]      w_bank_nxt [3][DEPTH];
    logic [N-1:0]      r_sh0;
    logic [N-1:0]      r_sh1;
    logic [N-1:0]      r_sh2;
    logic [N-1:0]      w_sh_vote;
    logic              w_sh_mismatch;
    logic              w_wr_hit;
    logic              w_patch_we;
    logic [N-1:0]      w_rd_vote;
    logic [N-1:0]      r_rd_data;
    logic              r_rd_valid;
    logic              r_patch_pulse;
    logic [AW-1:0]     r_patch_addr;
    logic [CNT_W-1:0]  r_patch_count;

    function automatic logic [N-1:0] f_vote(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [N-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Repair decisions use the shadow snapshot, so a flip landing after READ survives until the next pass.
    assign w_sh_vote     = f_vote(r_sh0, r_sh1, r_sh2);
    assign w_sh_mismatch = (r_sh0 != r_sh1) || (r_sh1 != r_sh2);
    assign w_wr_hit      = wr_en && (wr_addr == r_ptr);
    assign w_patch_we    = (r_state == S_PATCH) && !w_wr_hit;
    assign w_rd_vote     = f_vote(r_bank[0][rd_addr], r_bank[1][rd_addr], r_bank[2][rd_addr]);

    // Next bank contents: user write beats patch, then any flip is XORed on top of the result.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            for (int a = 0; a < DEPTH; a++) begin
                w_bank_nxt[c][a] = r_bank[c][a];
                if (wr_en && (wr_addr == AW'(a))) begin
                    w_bank_nxt[c][a] = wr_data;
                end else if (w_patch_we && (r_ptr == AW'(a))) begin
                    w_bank_nxt[c][a] = w_sh_vote;
                end
                if (flip_en && (flip_copy == 2'(c)) && (flip_addr == AW'(a))) begin
                    w_bank_nxt[c][a] = w_bank_nxt[c][a] ^ flip_mask;
                end
            end
        end
    end

    // Bank storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    r_bank[c][a] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    r_bank[c][a] <= w_bank_nxt[c][a];
                end
            end
        end
    end

    // Voted read port; samples the bank before this edge's writes, flips and patches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_vote;
            end
        end
    end

    // Scrubber state register, word pointer and shadow snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_READ) begin
                r_sh0 <= r_bank[0][r_ptr];
                r_sh1 <= r_bank[1][r_ptr];
                r_sh2 <= r_bank[2][r_ptr];
            end
            if (r_state == S_ADVANCE) begin
                r_ptr <= r_ptr + AW'(1);
            end
        end
    end

    // Scrubber next-state: scrub_en is only looked at between words, so a started word always completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (scrub_en) w_state_nxt = S_READ;
            S_READ:    w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_wr_hit)           w_state_nxt = S_ADVANCE;
                else if (w_sh_mismatch) w_state_nxt = S_PATCH;
                else                    w_state_nxt = S_ADVANCE;
            end
            S_PATCH:   w_state_nxt = S_ADVANCE;
            S_ADVANCE: w_state_nxt = scrub_en ? S_READ : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Repair reporting: pulse, last repaired address and saturating repair count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_patch_pulse <= 1'b0;
            r_patch_addr  <= '0;
            r_patch_count <= '0;
        end else begin
            r_patch_pulse <= w_patch_we;
            if (w_patch_we) begin
                r_patch_addr <= r_ptr;
                if (r_patch_count != {CNT_W{1'b1}}) begin
                    r_patch_count <= r_patch_count + CNT_W'(1);
                end
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign patch_pulse = r_patch_pulse;
    assign patch_addr  = r_patch_addr;
    assign patch_count = r_patch_count;
    assign scrub_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_tmr_flip_scrubber.sv
// Purpose: directed bench for tmr_flip_scrubber with hand-computed expectations.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is fully scripted.
module tb_tmr_flip_scrubber;

    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int AW    = 3;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [N-1:0]     wr_data;
    logic             flip_en;
    logic [1:0]       flip_copy;
    logic [AW-1:0]    flip_addr;
    logic [N-1:0]     flip_mask;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [N-1:0]     rd_data;
    logic             rd_valid;
    logic             scrub_en;
    logic             patch_pulse;
    logic [AW-1:0]    patch_addr;
    logic [CNT_W-1:0] patch_count;
    logic             scrub_busy;

    int checks  = 0;
    int errors  = 0;
    int n_pulse = 0;
    int p0;

    tmr_flip_scrubber #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .flip_en     (flip_en),
        .flip_copy   (flip_copy),
        .flip_addr   (flip_addr),
        .flip_mask   (flip_mask),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .scrub_en    (scrub_en),
        .patch_pulse (patch_pulse),
        .patch_addr  (patch_addr),
        .patch_count (patch_count),
        .scrub_busy  (scrub_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; samples outputs just after the edge and tallies repair pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (patch_pulse) n_pulse++;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [N-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_flip(input logic [1:0] c, input logic [AW-1:0] a, input logic [N-1:0] m);
        flip_en = 1'b1; flip_copy = c; flip_addr = a; flip_mask = m;
        tick();
        flip_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    // Keep scrub_en high for n_en edges, then drop it so the final ADVANCE returns to IDLE.
    task automatic run_scrub(input int n_en);
        scrub_en = 1'b1;
        repeat (n_en) tick();
        scrub_en = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        flip_en = 1'b0; flip_copy = '0; flip_addr = '0; flip_mask = '0;
        rd_en = 1'b0; rd_addr = '0; scrub_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_pulse", 32'(patch_pulse), 32'h0);
        check("rst_paddr", 32'(patch_addr), 32'h0);
        check("rst_count", 32'(patch_count), 32'h0);
        check("rst_busy", 32'(scrub_busy), 32'h0);

        // 1: write/read, one-cycle valid, read-before-write, clean pass
        do_write(3'd3, 16'hA5A5);
        do_read(3'd3);
        check("t1_rd_data", 32'(rd_data), 32'hA5A5);
        check("t1_rd_valid", 32'(rd_valid), 32'h1);
        tick();
        check("t1_valid_drop", 32'(rd_valid), 32'h0);
        check("t1_data_hold", 32'(rd_data), 32'hA5A5);
        rd_en = 1'b1; rd_addr = 3'd3;
        do_write(3'd3, 16'h5A5A);
        rd_en = 1'b0;
        check("t1_rd_old", 32'(rd_data), 32'hA5A5);
        do_read(3'd3);
        check("t1_rd_new", 32'(rd_data), 32'h5A5A);
        p0 = n_pulse;
        run_scrub(3 * DEPTH);
        check("t1_pass_busy", 32'(scrub_busy), 32'h0);
        check("t1_pulses", 32'(n_pulse - p0), 32'h0);
        check("t1_count", 32'(patch_count), 32'h0);

        // 2: single-copy flip is voted out and repaired
        do_write(3'd5, 16'h00FF);
        do_flip(2'd1, 3'd5, 16'h0101);
        check("t2_copy1_flipped", 32'(dut.r_bank[1][5]), 32'h01FE);
        do_read(3'd5);
        check("t2_rd_vote", 32'(rd_data), 32'h00FF);
        p0 = n_pulse;
        run_scrub(3 * DEPTH + 1);
        check("t2_busy", 32'(scrub_busy), 32'h0);
        check("t2_pulses", 32'(n_pulse - p0), 32'h1);
        check("t2_paddr", 32'(patch_addr), 32'h5);
        check("t2_count", 32'(patch_count), 32'h1);
        check("t2_copy1_fixed", 32'(dut.r_bank[1][5]), 32'h00FF);
        do_flip(2'd3, 3'd5, 16'hFFFF);
        check("t2_copy3_noop0", 32'(dut.r_bank[0][5]), 32'h00FF);
        check("t2_copy3_noop2", 32'(dut.r_bank[2][5]), 32'h00FF);

        // 3: two copies flipped in different bits, one repair
        do_write(3'd0, 16'h1234);
        do_flip(2'd0, 3'd0, 16'h0001);
        do_flip(2'd2, 3'd0, 16'h8000);
        do_read(3'd0);
        check("t3_rd_vote", 32'(rd_data), 32'h1234);
        p0 = n_pulse;
        run_scrub(3 * DEPTH + 1);
        check("t3_pulses", 32'(n_pulse - p0), 32'h1);
        check("t3_paddr", 32'(patch_addr), 32'h0);
        check("t3_count", 32'(patch_count), 32'h2);
        check("t3_copy0", 32'(dut.r_bank[0][0]), 32'h1234);
        check("t3_copy2", 32'(dut.r_bank[2][0]), 32'h1234);

        // 4: repair on last word, two passes with pointer wrap
        do_flip(2'd2, 3'd7, 16'h0F0F);
        p0 = n_pulse;
        run_scrub(2 * 3 * DEPTH + 1);
        check("t4_busy", 32'(scrub_busy), 32'h0);
        check("t4_pulses", 32'(n_pulse - p0), 32'h1);
        check("t4_paddr", 32'(patch_addr), 32'h7);
        check("t4_count", 32'(patch_count), 32'h3);
        check("t4_ptr_wrap", 32'(dut.r_ptr), 32'h0);

        // 5: user write lands in the PATCH cycle of word 2
        do_flip(2'd0, 3'd2, 16'h0001);
        p0 = n_pulse;
        scrub_en = 1'b1;
        repeat (9) tick();
        do_write(3'd2, 16'hBEEF);
        repeat (15) tick();
        scrub_en = 1'b0;
        tick();
        check("t5_busy", 32'(scrub_busy), 32'h0);
        check("t5_pulses", 32'(n_pulse - p0), 32'h0);
        check("t5_count", 32'(patch_count), 32'h3);
        check("t5_paddr", 32'(patch_addr), 32'h7);
        check("t5_copy0", 32'(dut.r_bank[0][2]), 32'hBEEF);
        do_read(3'd2);
        check("t5_rd_vote", 32'(rd_data), 32'hBEEF);

        // 6: 17 repairs saturate a 4-bit counter
        for (int i = 0; i < DEPTH; i++) do_flip(2'(i % 3), AW'(i), N'(1) << i);
        p0 = n_pulse;
        run_scrub(3 * DEPTH + DEPTH);
        check("t6_pulses_a", 32'(n_pulse - p0), 32'h8);
        check("t6_count_a", 32'(patch_count), 32'hB);
        for (int i = 0; i < DEPTH; i++) do_flip(2'((i + 1) % 3), AW'(i), N'(16'h0100) << i);
        p0 = n_pulse;
        run_scrub(3 * DEPTH + DEPTH);
        check("t6_pulses_b", 32'(n_pulse - p0), 32'h8);
        check("t6_count_b", 32'(patch_count), 32'hF);
        do_flip(2'd0, 3'd6, 16'h4000);
        p0 = n_pulse;
        run_scrub(3 * DEPTH + 1);
        check("t6_pulses_c", 32'(n_pulse - p0), 32'h1);
        check("t6_count_sat", 32'(patch_count), 32'hF);

        // Reset asserted while in PATCH for word 4
        do_read(3'd2);
        check("t6_rd_pre", 32'(rd_data), 32'hBEEF);
        do_flip(2'd1, 3'd4, 16'h0010);
        p0 = n_pulse;
        scrub_en = 1'b1;
        repeat (15) tick();
        check("t6_busy_patch", 32'(scrub_busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_rd_data", 32'(rd_data), 32'h0);
        check("t6_rst_rd_valid", 32'(rd_valid), 32'h0);
        check("t6_rst_pulse", 32'(patch_pulse), 32'h0);
        check("t6_rst_paddr", 32'(patch_addr), 32'h0);
        check("t6_rst_count", 32'(patch_count), 32'h0);
        check("t6_rst_busy", 32'(scrub_busy), 32'h0);
        scrub_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("t6_no_pulse", 32'(n_pulse - p0), 32'h0);
        check("t6_bank_clear", 32'(dut.r_bank[1][4]), 32'h0);
        check("t6_count_after", 32'(patch_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
